// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and helpers for the data-side memory unit.
// memCtrl codes, FSM states and access-size decode.
package mem_pkg;

  localparam logic [2:0] MC_LB  = 3'd0;
  localparam logic [2:0] MC_LH  = 3'd1;
  localparam logic [2:0] MC_LW  = 3'd2;
  localparam logic [2:0] MC_LBU = 3'd3;
  localparam logic [2:0] MC_LHU = 3'd4;
  localparam logic [2:0] MC_SB  = 3'd5;
  localparam logic [2:0] MC_SH  = 3'd6;
  localparam logic [2:0] MC_SW  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  function automatic logic is_load(
    input logic [2:0] mc
  );
    return mc <= MC_LHU;
  endfunction

  function automatic size_t size_of(
    input logic [2:0] mc
  );
    size_t s;
    unique case (mc)
      MC_LB, MC_LBU, MC_SB: s = SZ_B;
      MC_LH, MC_LHU, MC_SH: s = SZ_H;
      default:              s = SZ_W;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering between core and a word bus.
// Store side builds enables/replicated data, load side extracts/extends.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_ctrl,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_ctrl,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] b_sh;
  logic [31:0] h_sh;

  // Store lanes: enable the addressed bytes, replicate data on all lanes
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    unique case (size_of(st_ctrl))
      SZ_B: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Load lanes: shift the addressed lane down, then sign/zero extend
  always_comb begin
    b_sh = ld_word >> {ld_off, 3'b000};
    h_sh = ld_word >> {ld_off[1], 4'b0000};
    unique case (ld_ctrl)
      MC_LB:   ld_data = {{24{b_sh[7]}}, b_sh[7:0]};
      MC_LBU:  ld_data = {24'd0, b_sh[7:0]};
      MC_LH:   ld_data = {{16{h_sh[15]}}, h_sh[15:0]};
      MC_LHU:  ld_data = {16'd0, h_sh[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one load/store per instruction over a req/ack bus.
// Stalls the pipeline until done; reports illegal/misaligned/timeout.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRD,
  input  logic        memWR,
  input  logic [2:0]  memCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        access_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] TMAX =
    CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ld_ctrl;
  logic [1:0]       ld_off;
  logic             misal;
  logic             err;
  logic             go;
  logic             bad;
  logic [3:0]       be_c;
  logic [31:0]      wd_c;
  logic [31:0]      ld_data;

  mem_lane_align u_align (
    .st_ctrl  (memCtrl),
    .st_off   (addr[1:0]),
    .st_data  (wdata),
    .st_be    (be_c),
    .st_wdata (wd_c),
    .ld_ctrl  (ld_ctrl),
    .ld_off   (ld_off),
    .ld_word  (bus_rdata),
    .ld_data  (ld_data)
  );

  // Request legality and alignment, only meaningful in IDLE
  always_comb begin
    misal = 1'b0;
    unique case (size_of(memCtrl))
      SZ_H:    misal = addr[0];
      SZ_W:    misal = |addr[1:0];
      default: misal = 1'b0;
    endcase
    err = (memRD & memWR)
        | (memRD & ~is_load(memCtrl))
        | (memWR & is_load(memCtrl))
        | ((memRD | memWR) & misal);
    go  = (state == IDLE) & (memRD ^ memWR) & ~err;
    bad = (state == IDLE) & (memRD | memWR) & err;
  end

  assign stall = go | (state == REQ);

  // Access FSM with registered bus and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_ctrl    <= '0;
      ld_off     <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      rdata      <= '0;
      access_err <= 1'b0;
    end else begin
      access_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bad) begin
            access_err <= 1'b1;
          end else if (go) begin
            bus_req   <= 1'b1;
            bus_we    <= memWR;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_c;
            bus_wdata <= wd_c;
            ld_ctrl   <= memCtrl;
            ld_off    <= addr[1:0];
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= DONE;
            if (!bus_we) rdata <= ld_data;
          end else if (TIMEOUT != 0 && cnt == TMAX) begin
            bus_req    <= 1'b0;
            access_err <= 1'b1;
            rdata      <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + random loads/stores against a
// byte-level reference model of the memory access unit.
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRD, memWR;
  logic [2:0]  memCtrl;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        access_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] ref_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .memRD      (memRD),
    .memWR      (memWR),
    .memCtrl    (memCtrl),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .access_err (access_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] c);
    if (c == 3'd0 || c == 3'd3 || c == 3'd5) return 1;
    if (c == 3'd1 || c == 3'd4 || c == 3'd6) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] mask_of(input int nb);
    if (nb == 4) return 32'hFFFF_FFFF;
    return (32'd1 << (8 * nb)) - 32'd1;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] c,
                                        input logic [31:0] a);
    int nb = nbytes(c);
    logic [3:0] m = 4'((1 << nb) - 1);
    return m << (a % 4);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] c,
                                         input logic [31:0] wd);
    int nb = nbytes(c);
    logic [31:0] r = 32'd0;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = wd[8*(b % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    int nb = nbytes(c);
    logic [31:0] m = mask_of(nb);
    logic [31:0] v = (w >> (8 * (a % 4))) & m;
    bit sgn = (c == 3'd0 || c == 3'd1);
    if (sgn && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic go_idle();
    memRD   = 1'b0;
    memWR   = 1'b0;
    memCtrl = 3'($urandom);
    addr    = $urandom;
    wdata   = $urandom;
  endtask

  // Entered and left at a negedge in an IDLE cycle; dly<0 = never ack
  task automatic access(input logic rd, input logic wr,
                        input logic [2:0] c,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int dly,
                        input logic [31:0] word);
    int nb = nbytes(c);
    bit req = rd | wr;
    bit bad = !(rd ^ wr) || (rd && c > 3'd4) ||
              (wr && c < 3'd5) || (a % nb != 0);
    bit tmo = 1'b0;
    memRD = rd; memWR = wr; memCtrl = c; addr = a; wdata = wd;
    #1 chk("stall_accept", 32'(stall), 32'(!bad));
    if (bad) begin
      @(negedge clk);
      go_idle();
      #1;
      chk("err_pulse", 32'(access_err), 32'(req));
      chk("err_no_req", 32'(bus_req), 32'd0);
      chk("err_stall", 32'(stall), 32'd0);
      chk("err_rdata", rdata, ref_rdata);
      @(negedge clk);
      chk("err_clear", 32'(access_err), 32'd0);
      return;
    end
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("req_high", 32'(bus_req), 32'd1);
      chk("req_stall", 32'(stall), 32'd1);
      if (i == 0) begin
        chk("bus_we", 32'(bus_we), 32'(wr));
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        chk("bus_be", 32'(bus_be), 32'(exp_be(c, a)));
        if (wr) chk("bus_wdata", bus_wdata, exp_wd(c, wd));
      end
      if (i == dly) begin
        bus_ack = 1'b1;
        bus_rdata = word;
        break;
      end
      if (i == TO - 1) tmo = 1'b1;
    end
    if (tmo) ref_rdata = 32'd0;
    else if (rd) ref_rdata = exp_ld(c, a, word);
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    chk("done_req", 32'(bus_req), 32'd0);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_err", 32'(access_err), 32'(tmo));
    chk("done_rdata", rdata, ref_rdata);
    @(negedge clk);
    chk("no_reissue", 32'(bus_req), 32'd0);
    go_idle();
    if (tmo) begin
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("late_ack_req", 32'(bus_req), 32'd0);
      chk("late_ack_err", 32'(access_err), 32'd0);
      chk("late_ack_rd", rdata, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    go_idle();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(access_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access(1, 0, 3'd2, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    chk("lw_value", rdata, 32'hDEAD_BEEF);
    access(1, 0, 3'd0, 32'h103, 32'h0, 1, 32'h80FF_0000);
    chk("lb_value", rdata, 32'hFFFF_FF80);
    access(1, 0, 3'd3, 32'h103, 32'h0, 0, 32'h80FF_0000);
    chk("lbu_value", rdata, 32'h0000_0080);
    access(0, 1, 3'd6, 32'h202, 32'h1234_ABCD, 3, 32'h0);
    chk("sh_keeps_rdata", rdata, 32'h0000_0080);
    access(1, 0, 3'd2, 32'h101, 32'h0, 0, 32'h0);
    access(1, 0, 3'd6, 32'h200, 32'h0, 0, 32'h0);
    access(1, 1, 3'd2, 32'h200, 32'h0, 0, 32'h0);
    access(1, 0, 3'd1, 32'h102, 32'h0, 2, 32'h8001_7FFF);
    access(1, 0, 3'd2, 32'h400, 32'h0, -1, 32'h0);

    memRD = 1'b1; memWR = 1'b0; memCtrl = 3'd2;
    addr = 32'h300; wdata = 32'h0;
    @(negedge clk);
    chk("rstmid_req1", 32'(bus_req), 32'd1);
    @(negedge clk);
    chk("rstmid_req2", 32'(bus_req), 32'd1);
    rst = 1'b1;
    go_idle();
    @(negedge clk);
    chk("rstmid_req", 32'(bus_req), 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    bus_ack = 1'b0;
    ref_rdata = 32'd0;
    chk("rstmid_late_req", 32'(bus_req), 32'd0);
    chk("rstmid_late_rd", rdata, 32'd0);
    access(0, 1, 3'd5, 32'h3, 32'h5A, 1, 32'h0);

    for (int k = 0; k < 60; k++) begin
      logic [2:0]  c = 3'($urandom);
      logic [31:0] a = $urandom;
      int          r = $urandom_range(0, 11);
      logic        rd = (c <= 3'd4);
      logic        wr = !rd;
      if ($urandom_range(0, 3) != 0)
        a = a & ~(32'(nbytes(c)) - 32'd1);
      if (r == 0) begin rd = 1; wr = 1; end
      if (r == 1) begin rd = 0; wr = 0; end
      if (r == 2) begin rd = !rd; wr = !wr; end
      access(rd, wr, c, a, $urandom,
             $urandom_range(0, 4), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
